seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl_if.sv | 21 ++
 rtl/seg7_scan_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side bundle for seg7_scan_ctrl: display value/load strobe in,
// HC595 digit word and frame marker out.
interface seg7_scan_ctrl_if;
  logic        en;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic        load;
  logic [15:0] p_data;
  logic        frame_done;

  modport master (
    output en, data_in, dp_in, blank_in, load,
    input  p_data, frame_done
  );

  modport slave (
    input  en, data_in, dp_in, blank_in, load,
    output p_data, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed 7-segment scanner feeding the HC595 driver as {seg, sel}.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int          DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DIGITS - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } disp_t;

  logic [DW-1:0] div_cnt;
  logic [2:0]    digit_idx;
  logic [2:0]    next_idx;
  logic          tick;
  logic          wrap;
  logic          pending;
  disp_t         shadow;
  disp_t         active;
  disp_t         load_val;
  disp_t         frame_val;
  logic [7:0]    lzb;
  logic [3:0]    nib;
  logic          dark;
  logic [7:0]    seg_next;
  logic [7:0]    sel_next;
`ifdef SEG7_SCAN_LZB_EN
  logic          suppress;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    load_val = '{data: bus.data_in, dp: bus.dp_in, blank: bus.blank_in};
    tick     = (div_cnt == DIV_LAST);
    wrap     = tick && (digit_idx == IDX_LAST);
    next_idx = wrap ? 3'd0 : digit_idx + 3'd1;

    // Digit 0 of a new frame must already see the value being committed.
    frame_val = active;
    if (wrap) begin
      if (bus.load)
        frame_val = load_val;
      else if (pending)
        frame_val = shadow;
    end

    lzb = '0;
`ifdef SEG7_SCAN_LZB_EN
    suppress = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      suppress = suppress & (frame_val.data[4*k +: 4] == 4'h0) & ~frame_val.dp[k];
      lzb[k]   = suppress;
    end
`endif

    nib      = frame_val.data[{next_idx, 2'b00} +: 4];
    dark     = frame_val.blank[next_idx] | lzb[next_idx];
    seg_next = dark ? 8'hFF : {~frame_val.dp[next_idx], hex7(nib)};
    sel_next = ~(8'b1 << next_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt        <= '0;
      digit_idx      <= '0;
      pending        <= 1'b0;
      shadow         <= '0;
      active         <= '0;
      bus.p_data     <= 16'hFFFF;
      bus.frame_done <= 1'b0;
    end else begin
      div_cnt        <= tick ? '0 : div_cnt + 1'b1;
      bus.frame_done <= wrap;
      if (tick)
        digit_idx <= next_idx;

      if (wrap) begin
        active  <= frame_val;
        pending <= 1'b0;
        if (bus.load)
          shadow <= load_val;
      end else if (bus.load) begin
        shadow  <= load_val;
        pending <= 1'b1;
      end

      if (!bus.en)
        bus.p_data <= 16'hFFFF;
      else if (tick)
        bus.p_data <= {seg_next, sel_next};
    end
  end

endmodule
